// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared definitions for the accumulator-CPU control sequencer.
//   - opcode constants (OP_*)
//   - ALU function-select codes (ALUS_*), shared with the ALU
//   - bus source select codes (BUS_*)
//   - sequencer state enum and the decoded strobe struct
// Optional feature macro: CTRL_SEQ_HALT_EN (adds opcode FF -> HALT state).
package ctrl_pkg;

    localparam int OP_W   = 8;
    localparam int ALUS_W = 4;
    localparam int BUS_W  = 3;

    // Opcodes
    localparam logic [OP_W-1:0] OP_NOP  = 8'h00;
    localparam logic [OP_W-1:0] OP_LDAC = 8'h01;
    localparam logic [OP_W-1:0] OP_STAC = 8'h02;
    localparam logic [OP_W-1:0] OP_MVAC = 8'h03;
    localparam logic [OP_W-1:0] OP_MOVR = 8'h04;
    localparam logic [OP_W-1:0] OP_JUMP = 8'h05;
    localparam logic [OP_W-1:0] OP_JMPZ = 8'h06;
    localparam logic [OP_W-1:0] OP_JPNZ = 8'h07;
    localparam logic [OP_W-1:0] OP_ADD  = 8'h08;
    localparam logic [OP_W-1:0] OP_SUB  = 8'h09;
    localparam logic [OP_W-1:0] OP_INAC = 8'h0A;
    localparam logic [OP_W-1:0] OP_CLAC = 8'h0B;
    localparam logic [OP_W-1:0] OP_AND  = 8'h0C;
    localparam logic [OP_W-1:0] OP_OR   = 8'h0D;
    localparam logic [OP_W-1:0] OP_XOR  = 8'h0E;
    localparam logic [OP_W-1:0] OP_NOT  = 8'h0F;
    localparam logic [OP_W-1:0] OP_HALT = 8'hFF;

    // ALU function select
    localparam logic [ALUS_W-1:0] ALUS_CLAC = 4'd0;
    localparam logic [ALUS_W-1:0] ALUS_ADD  = 4'd1;
    localparam logic [ALUS_W-1:0] ALUS_SUB  = 4'd2;
    localparam logic [ALUS_W-1:0] ALUS_INAC = 4'd3;
    localparam logic [ALUS_W-1:0] ALUS_AND  = 4'd4;
    localparam logic [ALUS_W-1:0] ALUS_OR   = 4'd5;
    localparam logic [ALUS_W-1:0] ALUS_NOT  = 4'd6;
    localparam logic [ALUS_W-1:0] ALUS_XOR  = 4'd7;
    localparam logic [ALUS_W-1:0] ALUS_PASS = 4'd8;

    // Bus source select
    localparam logic [BUS_W-1:0] BUS_NONE = 3'd0;
    localparam logic [BUS_W-1:0] BUS_PC   = 3'd1;
    localparam logic [BUS_W-1:0] BUS_DR   = 3'd2;
    localparam logic [BUS_W-1:0] BUS_ADDR = 3'd3;  // {DR,TR} operand address
    localparam logic [BUS_W-1:0] BUS_R    = 3'd4;
    localparam logic [BUS_W-1:0] BUS_AC   = 3'd5;
    localparam logic [BUS_W-1:0] BUS_MEM  = 3'd6;

    typedef enum logic [4:0] {
        S_FETCH1,
        S_FETCH2,
        S_FETCH3,
        S_NOP,
        S_MVAC,
        S_MOVR,
        S_ALU,
        S_ADR1,
        S_ADR2,
        S_ADR3,
        S_LD4,
        S_LD5,
        S_ST4,
        S_ST5,
        S_JMP3,
        S_SKIP1,
        S_SKIP2
`ifdef CTRL_SEQ_HALT_EN
        , S_HALT
`endif
    } state_t;

    typedef struct packed {
        logic [ALUS_W-1:0] alus;
        logic [BUS_W-1:0]  bus_sel;
        logic ar_ld;
        logic ar_inc;
        logic pc_ld;
        logic pc_inc;
        logic dr_ld;
        logic tr_ld;
        logic ir_ld;
        logic r_ld;
        logic ac_ld;
        logic z_ld;
        logic mem_rd;
        logic mem_wr;
        logic fetch;
        logic halted;   // only driven high when the halt feature is built in
    } strobes_t;

    // ALU-op opcodes 08..0F map to their ALU function; anything else clears.
    function automatic logic [ALUS_W-1:0] alus_of_op(input logic [OP_W-1:0] op);
        logic [ALUS_W-1:0] a;
        a = ALUS_CLAC;
        case (op)
            OP_ADD:  a = ALUS_ADD;
            OP_SUB:  a = ALUS_SUB;
            OP_INAC: a = ALUS_INAC;
            OP_CLAC: a = ALUS_CLAC;
            OP_AND:  a = ALUS_AND;
            OP_OR:   a = ALUS_OR;
            OP_XOR:  a = ALUS_XOR;
            OP_NOT:  a = ALUS_NOT;
            default: a = ALUS_CLAC;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/ctrl_seq_if.sv
// ctrl_seq_if: control strobe bundle from the sequencer to the datapath.
//   master (sequencer): drives alus, bus_sel, register/memory strobes,
//                       fetch, halted (CTRL_SEQ_HALT_EN only), state (debug).
//   slave  (datapath):  receives all of the above.
// There is no handshake: every signal is a Moore output valid for the whole
// clock cycle and acted on by the datapath at the next rising edge.
interface ctrl_seq_if;
    import ctrl_pkg::*;

    logic [ALUS_W-1:0] alus;
    logic [BUS_W-1:0]  bus_sel;
    logic ar_ld, ar_inc, pc_ld, pc_inc, dr_ld, tr_ld, ir_ld, r_ld, ac_ld, z_ld;
    logic mem_rd, mem_wr;
    logic fetch;
`ifdef CTRL_SEQ_HALT_EN
    logic halted;
`endif
    state_t state;   // debug view of the sequencer state

    modport master (
        output alus, bus_sel, ar_ld, ar_inc, pc_ld, pc_inc, dr_ld, tr_ld,
               ir_ld, r_ld, ac_ld, z_ld, mem_rd, mem_wr, fetch,
`ifdef CTRL_SEQ_HALT_EN
               halted,
`endif
               state
    );

    modport slave (
        input  alus, bus_sel, ar_ld, ar_inc, pc_ld, pc_inc, dr_ld, tr_ld,
               ir_ld, r_ld, ac_ld, z_ld, mem_rd, mem_wr, fetch,
`ifdef CTRL_SEQ_HALT_EN
               halted,
`endif
               state
    );
endinterface

// File: rtl/ctrl_seq_decode.sv
// ctrl_seq_decode: combinational state/opcode -> strobe vector.
//   state : current sequencer state
//   op    : latched opcode (selects the ALU function in S_ALU)
//   s     : decoded strobes; anything not set for a state stays 0
// Optional feature macro: CTRL_SEQ_HALT_EN (HALT decodes to all-zero + halted).
module ctrl_seq_decode
    import ctrl_pkg::*;
(
    input  state_t          state,
    input  logic [OP_W-1:0] op,
    output strobes_t        s
);

    always_comb begin
        s = '0;
        case (state)
            S_FETCH1: begin
                s.ar_ld   = 1'b1;
                s.bus_sel = BUS_PC;
                s.fetch   = 1'b1;
            end
            S_FETCH2: begin
                s.mem_rd  = 1'b1;
                s.bus_sel = BUS_MEM;
                s.dr_ld   = 1'b1;
                s.pc_inc  = 1'b1;
            end
            S_FETCH3: begin
                // DR->IR uses a dedicated path, so the bus is free for PC->AR.
                s.ir_ld   = 1'b1;
                s.ar_ld   = 1'b1;
                s.bus_sel = BUS_PC;
            end
            S_NOP: ;
            S_MVAC: begin
                s.r_ld    = 1'b1;
                s.bus_sel = BUS_AC;
            end
            S_MOVR: begin
                s.ac_ld   = 1'b1;
                s.z_ld    = 1'b1;
                s.bus_sel = BUS_R;
                s.alus    = ALUS_PASS;
            end
            S_ALU: begin
                s.ac_ld   = 1'b1;
                s.z_ld    = 1'b1;
                s.bus_sel = BUS_R;
                s.alus    = alus_of_op(op);
            end
            S_ADR1: begin
                s.mem_rd  = 1'b1;
                s.bus_sel = BUS_MEM;
                s.dr_ld   = 1'b1;
                s.pc_inc  = 1'b1;
                s.ar_inc  = 1'b1;
            end
            S_ADR2: begin
                // Low byte moves DR->TR while the high byte is read into DR.
                s.tr_ld   = 1'b1;
                s.mem_rd  = 1'b1;
                s.bus_sel = BUS_MEM;
                s.dr_ld   = 1'b1;
                s.pc_inc  = 1'b1;
            end
            S_ADR3: begin
                s.ar_ld   = 1'b1;
                s.bus_sel = BUS_ADDR;
            end
            S_LD4: begin
                s.mem_rd  = 1'b1;
                s.bus_sel = BUS_MEM;
                s.dr_ld   = 1'b1;
            end
            S_LD5: begin
                s.ac_ld   = 1'b1;
                s.z_ld    = 1'b1;
                s.bus_sel = BUS_DR;
                s.alus    = ALUS_PASS;
            end
            S_ST4: begin
                s.dr_ld   = 1'b1;
                s.bus_sel = BUS_AC;
            end
            S_ST5: begin
                s.mem_wr  = 1'b1;
                s.bus_sel = BUS_DR;
            end
            S_JMP3: begin
                s.pc_ld   = 1'b1;
                s.bus_sel = BUS_ADDR;
            end
            S_SKIP1, S_SKIP2: begin
                s.pc_inc  = 1'b1;
            end
`ifdef CTRL_SEQ_HALT_EN
            S_HALT: begin
                s.halted  = 1'b1;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/ctrl_seq.sv
// ctrl_seq: hardwired fetch/decode/execute sequencer for the 8-bit
// accumulator CPU (Moore FSM).
//   clk   : system clock
//   rst_n : asynchronous active-low reset (state -> FETCH1, opcode -> 00)
//   dr_op : DR contents; taken as the opcode in FETCH3
//   z_in  : zero flag; only consulted in FETCH3 for JMPZ/JPNZ
//   ctl   : strobe bundle to the datapath (ctrl_seq_if.master)
// Optional feature macro: CTRL_SEQ_HALT_EN. When defined, opcode FF enters a
// HALT state (all strobes 0, ctl.halted=1) held until reset; otherwise FF is a NOP.
module ctrl_seq
    import ctrl_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic [OP_W-1:0] dr_op,
    input  logic            z_in,
    ctrl_seq_if.master      ctl
);

    state_t          state_q, state_d;
    logic [OP_W-1:0] op_q, op_d;
    strobes_t        s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH1;
            op_q    <= OP_NOP;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
        end
    end

    always_comb begin
        state_d = S_FETCH1;
        op_d    = op_q;
        case (state_q)
            S_FETCH1: state_d = S_FETCH2;
            S_FETCH2: state_d = S_FETCH3;
            S_FETCH3: begin
                // Branch on the live DR value; op_q is not valid until next cycle.
                op_d = dr_op;
                case (dr_op)
                    OP_MVAC: state_d = S_MVAC;
                    OP_MOVR: state_d = S_MOVR;
                    OP_ADD, OP_SUB, OP_INAC, OP_CLAC,
                    OP_AND, OP_OR, OP_XOR, OP_NOT: state_d = S_ALU;
                    OP_LDAC, OP_STAC, OP_JUMP: state_d = S_ADR1;
                    OP_JMPZ: state_d = z_in  ? S_ADR1 : S_SKIP1;
                    OP_JPNZ: state_d = !z_in ? S_ADR1 : S_SKIP1;
`ifdef CTRL_SEQ_HALT_EN
                    OP_HALT: state_d = S_HALT;
`endif
                    default: state_d = S_NOP;
                endcase
            end
            S_ADR1: state_d = S_ADR2;
            S_ADR2: state_d = (op_q == OP_LDAC || op_q == OP_STAC) ? S_ADR3 : S_JMP3;
            S_ADR3: state_d = (op_q == OP_LDAC) ? S_LD4 : S_ST4;
            S_LD4:  state_d = S_LD5;
            S_ST4:  state_d = S_ST5;
            S_SKIP1: state_d = S_SKIP2;
`ifdef CTRL_SEQ_HALT_EN
            S_HALT: state_d = S_HALT;
`endif
            default: state_d = S_FETCH1;
        endcase
    end

    ctrl_seq_decode u_decode (
        .state (state_q),
        .op    (op_q),
        .s     (s)
    );

    assign ctl.alus    = s.alus;
    assign ctl.bus_sel = s.bus_sel;
    assign ctl.ar_ld   = s.ar_ld;
    assign ctl.ar_inc  = s.ar_inc;
    assign ctl.pc_ld   = s.pc_ld;
    assign ctl.pc_inc  = s.pc_inc;
    assign ctl.dr_ld   = s.dr_ld;
    assign ctl.tr_ld   = s.tr_ld;
    assign ctl.ir_ld   = s.ir_ld;
    assign ctl.r_ld    = s.r_ld;
    assign ctl.ac_ld   = s.ac_ld;
    assign ctl.z_ld    = s.z_ld;
    assign ctl.mem_rd  = s.mem_rd;
    assign ctl.mem_wr  = s.mem_wr;
    assign ctl.fetch   = s.fetch;
    assign ctl.state   = state_q;
`ifdef CTRL_SEQ_HALT_EN
    assign ctl.halted  = s.halted;
`else
    logic unused_halted;
    assign unused_halted = s.halted;
`endif

endmodule

// File: tb/tb_ctrl_seq.sv
// tb_ctrl_seq: directed stimulus with hand-written per-state expected strobe
// vectors, checked through an expected-value queue by a separate monitor.
module tb_ctrl_seq;

    localparam int W = 21;

    // strobe bit masks, order: ar_ld ar_inc pc_ld pc_inc dr_ld tr_ld ir_ld
    // r_ld ac_ld z_ld mem_rd mem_wr fetch
    localparam logic [12:0] AR_LD  = 13'h1000;
    localparam logic [12:0] AR_INC = 13'h0800;
    localparam logic [12:0] PC_LD  = 13'h0400;
    localparam logic [12:0] PC_INC = 13'h0200;
    localparam logic [12:0] DR_LD  = 13'h0100;
    localparam logic [12:0] TR_LD  = 13'h0080;
    localparam logic [12:0] IR_LD  = 13'h0040;
    localparam logic [12:0] R_LD   = 13'h0020;
    localparam logic [12:0] AC_LD  = 13'h0010;
    localparam logic [12:0] Z_LD   = 13'h0008;
    localparam logic [12:0] MEM_RD = 13'h0004;
    localparam logic [12:0] MEM_WR = 13'h0002;
    localparam logic [12:0] FETCH  = 13'h0001;

    logic       clk;
    logic       rst_n;
    logic [7:0] dr_op;
    logic       z_in;

    ctrl_seq_if ctl ();

    ctrl_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .dr_op (dr_op),
        .z_in  (z_in),
        .ctl   (ctl.master)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // scoreboard state
    logic [W-1:0] exp_q[$];
    string        name_q[$];
    int           total = 0;
    int           bad   = 0;

    logic         halted_obs;
    logic [W-1:0] obs;
`ifdef CTRL_SEQ_HALT_EN
    assign halted_obs = ctl.halted;
`else
    assign halted_obs = 1'b0;
`endif
    assign obs = {halted_obs, ctl.alus, ctl.bus_sel,
                  ctl.ar_ld, ctl.ar_inc, ctl.pc_ld, ctl.pc_inc, ctl.dr_ld,
                  ctl.tr_ld, ctl.ir_ld, ctl.r_ld, ctl.ac_ld, ctl.z_ld,
                  ctl.mem_rd, ctl.mem_wr, ctl.fetch};

    function automatic logic [W-1:0] mk(input logic h, input logic [3:0] a,
                                        input logic [2:0] b, input logic [12:0] s);
        return {h, a, b, s};
    endfunction

    // hand-written expected vectors per state
    logic [W-1:0] e_f1, e_f2, e_f3, e_nop, e_mvac, e_movr, e_adr1, e_adr2,
                  e_adr3, e_ld4, e_ld5, e_st4, e_st5, e_jmp3, e_skip, e_halt;

    // monitor: outputs are valid for the whole cycle; check 1ns after negedge
    logic [W-1:0] m_exp;
    string        m_name;
    always @(negedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            m_exp  = exp_q.pop_front();
            m_name = name_q.pop_front();
            total++;
            if (obs !== m_exp) begin
                bad++;
                $display("FAIL %s: got %h expected %h (t=%0t)", m_name, obs, m_exp, $time);
            end
        end
    end

    // driver tasks: called right after a negedge; set inputs, push the
    // expected output for the current cycle, advance one cycle
    task automatic cyc(input logic [W-1:0] e, input string nm,
                       input logic [7:0] op, input logic z);
        dr_op = op;
        z_in  = z;
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(negedge clk);
    endtask

    // z is presented only during FETCH3; other cycles carry its inverse
    task automatic do_fetch(input logic [7:0] op, input logic z);
        cyc(e_f1, "fetch1", 8'h00, ~z);
        cyc(e_f2, "fetch2", 8'h00, ~z);
        cyc(e_f3, "fetch3", op, z);
    endtask

    task automatic do_alu(input logic [7:0] op, input logic [3:0] a);
        do_fetch(op, 1'b0);
        cyc(mk(1'b0, a, 3'd4, AC_LD | Z_LD), $sformatf("alu_%h", op), 8'h00, 1'b1);
    endtask

    task automatic do_addr(input logic [7:0] op, input logic z);
        do_fetch(op, z);
        cyc(e_adr1, "adr1", 8'h00, ~z);
        cyc(e_adr2, "adr2", 8'h00, ~z);
    endtask

    // watchdog
    initial begin
        #100000;
        bad++;
        $display("FAIL watchdog: got timeout expected stimulus end");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        e_f1   = mk(1'b0, 4'd0, 3'd1, AR_LD | FETCH);
        e_f2   = mk(1'b0, 4'd0, 3'd6, MEM_RD | DR_LD | PC_INC);
        e_f3   = mk(1'b0, 4'd0, 3'd1, IR_LD | AR_LD);
        e_nop  = mk(1'b0, 4'd0, 3'd0, 13'h0);
        e_mvac = mk(1'b0, 4'd0, 3'd5, R_LD);
        e_movr = mk(1'b0, 4'd8, 3'd4, AC_LD | Z_LD);
        e_adr1 = mk(1'b0, 4'd0, 3'd6, MEM_RD | DR_LD | PC_INC | AR_INC);
        e_adr2 = mk(1'b0, 4'd0, 3'd6, TR_LD | MEM_RD | DR_LD | PC_INC);
        e_adr3 = mk(1'b0, 4'd0, 3'd3, AR_LD);
        e_ld4  = mk(1'b0, 4'd0, 3'd6, MEM_RD | DR_LD);
        e_ld5  = mk(1'b0, 4'd8, 3'd2, AC_LD | Z_LD);
        e_st4  = mk(1'b0, 4'd0, 3'd5, DR_LD);
        e_st5  = mk(1'b0, 4'd0, 3'd2, MEM_WR);
        e_jmp3 = mk(1'b0, 4'd0, 3'd3, PC_LD);
        e_skip = mk(1'b0, 4'd0, 3'd0, PC_INC);
        e_halt = mk(1'b1, 4'd0, 3'd0, 13'h0);

        rst_n = 1'b0;
        dr_op = 8'h00;
        z_in  = 1'b0;
        @(negedge clk);
        // reset state: FETCH1 decode while held
        cyc(e_f1, "reset_f1", 8'h00, 1'b0);
        cyc(e_f1, "reset_f1", 8'h0A, 1'b1);
        rst_n = 1'b1;

        // single-state executes
        do_fetch(8'h00, 1'b0); cyc(e_nop,  "nop",  8'h00, 1'b1);
        do_fetch(8'h03, 1'b0); cyc(e_mvac, "mvac", 8'h00, 1'b1);
        do_fetch(8'h04, 1'b0); cyc(e_movr, "movr", 8'h00, 1'b1);

        // ALU ops 08..0F
        do_alu(8'h08, 4'd1);
        do_alu(8'h09, 4'd2);
        do_alu(8'h0A, 4'd3);
        do_alu(8'h0B, 4'd0);
        do_alu(8'h0C, 4'd4);
        do_alu(8'h0D, 4'd5);
        do_alu(8'h0E, 4'd7);
        do_alu(8'h0F, 4'd6);

        // LDAC, 8 cycles
        do_addr(8'h01, 1'b0);
        cyc(e_adr3, "ldac_adr3", 8'h00, 1'b1);
        cyc(e_ld4,  "ld4",       8'h00, 1'b1);
        cyc(e_ld5,  "ld5",       8'h00, 1'b1);

        // STAC, 8 cycles
        do_addr(8'h02, 1'b1);
        cyc(e_adr3, "stac_adr3", 8'h00, 1'b0);
        cyc(e_st4,  "st4",       8'h00, 1'b0);
        cyc(e_st5,  "st5",       8'h00, 1'b0);

        // JUMP, 6 cycles
        do_addr(8'h05, 1'b0);
        cyc(e_jmp3, "jump_jmp3", 8'h00, 1'b1);

        // JMPZ taken / not taken
        do_addr(8'h06, 1'b1);
        cyc(e_jmp3, "jmpz_jmp3", 8'h00, 1'b0);
        do_fetch(8'h06, 1'b0);
        cyc(e_skip, "jmpz_skip1", 8'h00, 1'b1);
        cyc(e_skip, "jmpz_skip2", 8'h00, 1'b1);

        // JPNZ taken / not taken
        do_addr(8'h07, 1'b0);
        cyc(e_jmp3, "jpnz_jmp3", 8'h00, 1'b1);
        do_fetch(8'h07, 1'b1);
        cyc(e_skip, "jpnz_skip1", 8'h00, 1'b0);
        cyc(e_skip, "jpnz_skip2", 8'h00, 1'b0);

        // undefined opcode behaves as NOP
        do_fetch(8'h10, 1'b0); cyc(e_nop, "undef_nop", 8'h00, 1'b1);

        // reset in the middle of LD4, held for 3 cycles
        do_addr(8'h01, 1'b0);
        cyc(e_adr3, "ldac_adr3", 8'h00, 1'b1);
        exp_q.push_back(e_ld4);
        name_q.push_back("ld4_pre_reset");
        #2;
        rst_n = 1'b0;
        @(negedge clk);
        cyc(e_f1, "midrst_f1", 8'h00, 1'b0);
        cyc(e_f1, "midrst_f1", 8'h00, 1'b0);
        cyc(e_f1, "midrst_f1", 8'h00, 1'b0);
        rst_n = 1'b1;
        // first fetch after release: FETCH1 then FETCH2
        do_fetch(8'h03, 1'b0); cyc(e_mvac, "post_rst_mvac", 8'h00, 1'b0);

        // opcode FF
`ifdef CTRL_SEQ_HALT_EN
        do_fetch(8'hFF, 1'b0);
        for (int i = 0; i < 20; i++) cyc(e_halt, "halt", 8'h00, i[0]);
`else
        do_fetch(8'hFF, 1'b0); cyc(e_nop, "ff_nop", 8'h00, 1'b1);
        do_fetch(8'h00, 1'b0); cyc(e_nop, "nop_after_ff", 8'h00, 1'b0);
`endif

        @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
